// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: drives the data-memory req/ack bus,
// aligns store data, formats load data, and produces the MEM->WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic        reg_write,
  input  logic [1:0]  rf_wr_sel,
  input  logic [4:0]  wa,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] mem_wd,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_wa,
  output logic [1:0]  wb_rf_wr_sel,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_load_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic          memop;
  logic          aligned;
  logic          issue;
  logic          mis_ev;
  logic          done;
  logic          abort;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_last;

  logic [31:0]   st_wdata;
  logic [3:0]    st_be;

  // Instruction fields captured at issue so writeback does not depend on
  // the upstream keeping its inputs frozen for the whole access.
  logic [1:0]    lat_off;
  logic [1:0]    lat_size;
  logic          lat_uns;
  logic          lat_load;
  logic          lat_rw;
  logic [4:0]    lat_wa;
  logic [1:0]    lat_sel;
  logic [31:0]   lat_alu;

  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

  assign memop    = in_valid & (mem_read | mem_write);
  assign mem_wd   = alu_result;
  assign tmo_last = (tmo_cnt == CW'(TIMEOUT - 1));

  // Natural-alignment check; size 3 is never a legal access
  always_comb begin
    aligned = 1'b0;
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~alu_result[0];
      2'd2:    aligned = (alu_result[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // FSM next-state logic plus stall and event strobes
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = 1'b0;
    mis_ev    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          if (aligned) begin
            issue     = 1'b1;
            stall     = 1'b1;
            state_nxt = REQ;
          end else begin
            mis_ev = 1'b1;
          end
        end
      end
      REQ: begin
        // Ack wins over an expiring timeout in the same cycle
        if (dmem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_last) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store lane replication and byte enables; loads enable all lanes
  always_comb begin
    st_wdata = rs2;
    st_be    = 4'b1111;
    case (size)
      2'd0: begin
        st_wdata = {4{rs2[7:0]}};
        st_be    = 4'b0001 << alu_result[1:0];
      end
      2'd1: begin
        st_wdata = {2{rs2[15:0]}};
        st_be    = 4'b0011 << alu_result[1:0];
      end
      default: begin
        st_wdata = rs2;
        st_be    = 4'b1111;
      end
    endcase
    if (!mem_write) begin
      st_be = 4'b1111;
    end
  end

  // Load lane selection followed by sign/zero extension
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (lat_off)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = dmem_rdata;
    case (lat_size)
      2'd0:    ld_data = lat_uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = lat_uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts unacknowledged REQ cycles; cleared whenever the access ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if ((state == REQ) && !done && !abort) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Bus outputs and captured instruction fields; held stable while in REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_uns    <= 1'b0;
      lat_load   <= 1'b0;
      lat_rw     <= 1'b0;
      lat_wa     <= '0;
      lat_sel    <= '0;
      lat_alu    <= '0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write;
      dmem_addr  <= {alu_result[31:2], 2'b00};
      dmem_wdata <= st_wdata;
      dmem_be    <= st_be;
      lat_off    <= alu_result[1:0];
      lat_size   <= size;
      lat_uns    <= is_unsigned;
      lat_load   <= mem_read & ~mem_write;
      lat_rw     <= reg_write;
      lat_wa     <= wa;
      lat_sel    <= rf_wr_sel;
      lat_alu    <= alu_result;
    end else if (done || abort) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end
  end

  // MEM->WB register and one-cycle exception flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_wa         <= '0;
      wb_rf_wr_sel  <= '0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign <= mis_ev;
      bus_err  <= abort;
      if ((state == IDLE) && !issue) begin
        wb_valid      <= in_valid;
        wb_reg_write  <= in_valid & reg_write & ~mis_ev;
        wb_wa         <= wa;
        wb_rf_wr_sel  <= rf_wr_sel;
        wb_alu_result <= alu_result;
        wb_load_data  <= '0;
      end else if (done) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= lat_rw;
        wb_wa         <= lat_wa;
        wb_rf_wr_sel  <= lat_sel;
        wb_alu_result <= lat_alu;
        wb_load_data  <= lat_load ? ld_data : '0;
      end else if (abort) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= 1'b0;
        wb_wa         <= lat_wa;
        wb_rf_wr_sel  <= lat_sel;
        wb_alu_result <= lat_alu;
        wb_load_data  <= '0;
      end else begin
        // Access still in flight: hand WB a bubble
        wb_valid      <= 1'b0;
        wb_reg_write  <= 1'b0;
        wb_load_data  <= '0;
      end
    end
  end

endmodule
